// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA) arbiter and access sequencer for the single-port data memory.
// Every grant runs IDLE -> ACCESS (1 + WAIT_STATES cycles) -> DONE (one-cycle ack to the owner).
module dmem_arbiter #(
  parameter int WORD_LEN    = 32,
  parameter int WAIT_STATES = 0,
  parameter bit CPU_FIRST   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [WORD_LEN-1:0] cpu_addr,
  input  logic [WORD_LEN-1:0] cpu_wdata,
  output logic [WORD_LEN-1:0] cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_stall,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [WORD_LEN-1:0] dma_addr,
  input  logic [WORD_LEN-1:0] dma_wdata,
  output logic [WORD_LEN-1:0] dma_rdata,
  output logic                dma_ack,
  output logic                mem_writeEn,
  output logic                mem_readEn,
  output logic [WORD_LEN-1:0] mem_address,
  output logic [WORD_LEN-1:0] mem_dataIn,
  input  logic [WORD_LEN-1:0] mem_dataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_ptr_cpu, w_ptr_cpu_nxt;
  logic                r_own_dma, w_own_dma_nxt;
  logic                r_we, w_we_nxt;
  logic                r_cpu_ack, w_cpu_ack_nxt;
  logic                r_dma_ack, w_dma_ack_nxt;
  logic [WORD_LEN-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [WORD_LEN-1:0] r_dma_rdata, w_dma_rdata_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_mem_re, w_mem_re_nxt;
  logic [WORD_LEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WORD_LEN-1:0] r_mem_din, w_mem_din_nxt;

  logic w_grant_dma;
  logic w_sel_we;

  // DMA wins when it is alone, or on a tie when the pointer does not favour the CPU.
  assign w_grant_dma = dma_req & (~cpu_req | ~r_ptr_cpu);
  assign w_sel_we    = w_grant_dma ? dma_we : cpu_we;

  always_comb begin
    // NOTE: every value written below gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ptr_cpu_nxt   = r_ptr_cpu;
    w_own_dma_nxt   = r_own_dma;
    w_we_nxt        = r_we;
    w_cpu_ack_nxt   = 1'b0;
    w_dma_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;

    case (r_state)
      IDLE: begin
        if (cpu_req | dma_req) begin
          w_state_nxt    = ACCESS;
          w_own_dma_nxt  = w_grant_dma;
          w_we_nxt       = w_sel_we;
          w_mem_addr_nxt = w_grant_dma ? dma_addr  : cpu_addr;
          w_mem_din_nxt  = w_grant_dma ? dma_wdata : cpu_wdata;
          w_cnt_nxt      = WS_LOAD;
          w_ptr_cpu_nxt  = w_grant_dma;
          // Enables are registered, so they are set up here for the first ACCESS cycle.
          w_mem_re_nxt   = ~w_sel_we;
          w_mem_we_nxt   = w_sel_we & (WS_LOAD == 4'd0);
        end
      end
      ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt    = r_cnt - 4'd1;
          w_mem_re_nxt = ~r_we;
          w_mem_we_nxt = r_we & (r_cnt == 4'd1);
        end else begin
          w_state_nxt = DONE;
          if (!r_we) begin
            if (r_own_dma) w_dma_rdata_nxt = mem_dataOut;
            else           w_cpu_rdata_nxt = mem_dataOut;
          end
          w_cpu_ack_nxt = ~r_own_dma;
          w_dma_ack_nxt = r_own_dma;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ptr_cpu   <= CPU_FIRST;
      r_own_dma   <= 1'b0;
      r_we        <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr_cpu   <= w_ptr_cpu_nxt;
      r_own_dma   <= w_own_dma_nxt;
      r_we        <= w_we_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
    end
  end

  // A reset arriving in the write cycle must stop the write reaching the memory this same cycle.
  assign mem_writeEn = r_mem_we & ~rst;
  assign mem_readEn  = r_mem_re;
  assign mem_address = r_mem_addr;
  assign mem_dataIn  = r_mem_din;
  assign cpu_ack     = r_cpu_ack;
  assign dma_ack     = r_dma_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign dma_rdata   = r_dma_rdata;
  assign cpu_stall   = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors and sequences on a WAIT_STATES=0 and a WAIT_STATES=3
// instance, then random traffic on the first one against a transaction-schedule reference model.
module tb_dmem_arbiter;
  localparam int W    = 32;
  localparam int WS_A = 0;
  localparam int WS_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         cpu_req_a, cpu_we_a, cpu_ack_a, cpu_stall_a;
  logic [W-1:0] cpu_addr_a, cpu_wdata_a, cpu_rdata_a;
  logic         dma_req_a, dma_we_a, dma_ack_a;
  logic [W-1:0] dma_addr_a, dma_wdata_a, dma_rdata_a;
  logic         mem_we_a, mem_re_a;
  logic [W-1:0] mem_address_a, mem_dataIn_a, mem_dataOut_a;

  logic         cpu_req_b, cpu_we_b, cpu_ack_b, cpu_stall_b;
  logic [W-1:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b;
  logic         dma_req_b, dma_we_b, dma_ack_b;
  logic [W-1:0] dma_addr_b, dma_wdata_b, dma_rdata_b;
  logic         mem_we_b, mem_re_b;
  logic [W-1:0] mem_address_b, mem_dataIn_b, mem_dataOut_b;

  dmem_arbiter #(.WORD_LEN(W), .WAIT_STATES(WS_A), .CPU_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
    .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a), .cpu_stall(cpu_stall_a),
    .dma_req(dma_req_a), .dma_we(dma_we_a), .dma_addr(dma_addr_a), .dma_wdata(dma_wdata_a),
    .dma_rdata(dma_rdata_a), .dma_ack(dma_ack_a),
    .mem_writeEn(mem_we_a), .mem_readEn(mem_re_a), .mem_address(mem_address_a),
    .mem_dataIn(mem_dataIn_a), .mem_dataOut(mem_dataOut_a));

  dmem_arbiter #(.WORD_LEN(W), .WAIT_STATES(WS_B), .CPU_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_stall(cpu_stall_b),
    .dma_req(dma_req_b), .dma_we(dma_we_b), .dma_addr(dma_addr_b), .dma_wdata(dma_wdata_b),
    .dma_rdata(dma_rdata_b), .dma_ack(dma_ack_b),
    .mem_writeEn(mem_we_b), .mem_readEn(mem_re_b), .mem_address(mem_address_b),
    .mem_dataIn(mem_dataIn_b), .mem_dataOut(mem_dataOut_b));

  // Data memories: 64 words, write on the clock edge, combinational read, 0 below address 32.
  logic [W-1:0] mem_a [64];
  logic [W-1:0] mem_b [64];
  logic         mem_clr, pre_en_b;
  logic [5:0]   pre_idx;
  logic [W-1:0] pre_data;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 64; i++) mem_a[i] <= '0;
    else if (mem_we_a) mem_a[mem_address_a[7:2]] <= mem_dataIn_a;
  end
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 64; i++) mem_b[i] <= '0;
    else if (pre_en_b) mem_b[pre_idx] <= pre_data;
    else if (mem_we_b) mem_b[mem_address_b[7:2]] <= mem_dataIn_b;
  end
  assign mem_dataOut_a = (mem_address_a < 32'd32) ? '0 : mem_a[mem_address_a[7:2]];
  assign mem_dataOut_b = (mem_address_b < 32'd32) ? '0 : mem_b[mem_address_b[7:2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_req_a = 0; cpu_we_a = 0; cpu_addr_a = '0; cpu_wdata_a = '0;
    dma_req_a = 0; dma_we_a = 0; dma_addr_a = '0; dma_wdata_a = '0;
    cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0;
    dma_req_b = 0; dma_we_b = 0; dma_addr_b = '0; dma_wdata_b = '0;
  endtask

  // Returns at posedge+1 of the first cycle in which the DUTs sit in IDLE out of reset.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One transaction on instance A; k counts cycles from the request cycle T (k = 0).
  task automatic txn_a(input logic is_dma, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output int first_en,
                       output int n_we, output int n_re, output int n_oth, output logic ok,
                       output logic [31:0] rd_c, output logic [31:0] rd_d, output logic ack_after);
    lat = -1; first_en = -1; n_we = 0; n_re = 0; n_oth = 0; ok = 1'b1;
    rd_c = '0; rd_d = '0; ack_after = 1'b0;
    @(posedge clk); #1;
    if (is_dma) begin dma_req_a = 1; dma_we_a = we; dma_addr_a = addr; dma_wdata_a = wdata; end
    else        begin cpu_req_a = 1; cpu_we_a = we; cpu_addr_a = addr; cpu_wdata_a = wdata; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((mem_we_a | mem_re_a) && first_en < 0) first_en = k;
      if (mem_we_a) n_we++;
      if (mem_re_a) n_re++;
      if ((mem_we_a | mem_re_a) && mem_address_a !== addr) ok = 1'b0;
      if (mem_we_a && mem_dataIn_a !== wdata) ok = 1'b0;
      if (is_dma ? cpu_ack_a : dma_ack_a) n_oth++;
      if (is_dma ? dma_ack_a : cpu_ack_a) begin
        lat = k; rd_c = cpu_rdata_a; rd_d = dma_rdata_a;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req_a = 0; dma_req_a = 0;
    @(negedge clk);
    ack_after = cpu_ack_a | dma_ack_a;
  endtask

  typedef struct {
    string       name;
    logic        is_dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  // Reference model state for the random phase (transaction schedule, not cycle FSM).
  logic [31:0] ref_mem [64];
  int          m_cyc, m_g, m_free;
  logic        m_have, m_dma, m_we, m_fav_dma;
  logic [31:0] m_addr, m_wdata, m_rd_cpu, m_rd_dma;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a < 32'd32) ? 32'd0 : ref_mem[a[7:2]];
  endfunction

  task automatic model_step();
    logic e_cack, e_dack, e_we, e_re;
    int   ack_cyc;
    e_cack = 0; e_dack = 0; e_we = 0; e_re = 0;
    if (m_have) begin
      ack_cyc = m_g + 2 + WS_A;
      e_cack  = !m_dma && (m_cyc == ack_cyc);
      e_dack  = m_dma && (m_cyc == ack_cyc);
      e_we    = m_we && (m_cyc == ack_cyc - 1);
      e_re    = !m_we && (m_cyc >= m_g + 1) && (m_cyc <= ack_cyc - 1);
      if (m_cyc == ack_cyc) begin
        if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
        else if (m_dma) m_rd_dma = ref_read(m_addr);
        else m_rd_cpu = ref_read(m_addr);
      end
    end
    check("rnd cpu_ack", {31'd0, cpu_ack_a}, {31'd0, e_cack});
    check("rnd dma_ack", {31'd0, dma_ack_a}, {31'd0, e_dack});
    check("rnd mem_writeEn", {31'd0, mem_we_a}, {31'd0, e_we});
    check("rnd mem_readEn", {31'd0, mem_re_a}, {31'd0, e_re});
    check("rnd cpu_stall", {31'd0, cpu_stall_a}, {31'd0, cpu_req_a & ~e_cack});
    check("rnd cpu_rdata", cpu_rdata_a, m_rd_cpu);
    check("rnd dma_rdata", dma_rdata_a, m_rd_dma);
    if (e_we | e_re) check("rnd mem_address", mem_address_a, m_addr);
    if (e_we) check("rnd mem_dataIn", mem_dataIn_a, m_wdata);
    if (m_cyc >= m_free && (cpu_req_a | dma_req_a)) begin
      m_dma     = dma_req_a && (!cpu_req_a || m_fav_dma);
      m_fav_dma = !m_dma;
      m_we      = m_dma ? dma_we_a : cpu_we_a;
      m_addr    = m_dma ? dma_addr_a : cpu_addr_a;
      m_wdata   = m_dma ? dma_wdata_a : cpu_wdata_a;
      m_g       = m_cyc;
      m_free    = m_cyc + 3 + WS_A;
      m_have    = 1;
    end
    m_cyc++;
  endtask

  initial begin
    int          lat, first_en, n_we, n_re, n_oth, c_at, d_at, cnt;
    logic        ok, ack_after, cpu_done, dma_done;
    logic [31:0] rd_c, rd_d, e_rd_c, e_rd_d;
    logic [2:0]  stl;
    logic [11:0] c_mask, d_mask;

    vecs[0] = '{"cpu wr 0x40",  1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{"cpu rd 0x40",  1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{"cpu rd 0x10",  1'b0, 1'b0, 32'h10, 32'h0,        32'h0};
    vecs[3] = '{"dma wr 0x80",  1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{"dma rd 0x80",  1'b1, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{"cpu rd 0x42",  1'b0, 1'b0, 32'h42, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{"cpu wr 0x14",  1'b0, 1'b1, 32'h14, 32'h11111111, 32'h0};
    vecs[7] = '{"cpu rd 0x14",  1'b0, 1'b0, 32'h14, 32'h0,        32'h0};
    vecs[8] = '{"dma rd 0x40",  1'b1, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};

    rst = 1; drive_idle();
    mem_clr = 1; pre_en_b = 0; pre_idx = '0; pre_data = '0;
    @(posedge clk); #1;
    mem_clr = 0;
    do_reset();

    @(negedge clk);
    check("reset flags a", {27'd0, cpu_ack_a, dma_ack_a, mem_we_a, mem_re_a, cpu_stall_a}, 32'd0);
    check("reset cpu_rdata a", cpu_rdata_a, 32'd0);
    check("reset dma_rdata a", dma_rdata_a, 32'd0);
    check("reset mem_address a", mem_address_a, 32'd0);
    check("reset mem_dataIn a", mem_dataIn_a, 32'd0);
    check("reset flags b", {27'd0, cpu_ack_b, dma_ack_b, mem_we_b, mem_re_b, cpu_stall_b}, 32'd0);

    e_rd_c = '0; e_rd_d = '0;
    for (int i = 0; i < 9; i++) begin
      txn_a(vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            lat, first_en, n_we, n_re, n_oth, ok, rd_c, rd_d, ack_after);
      if (!vecs[i].we) begin
        if (vecs[i].is_dma) e_rd_d = vecs[i].exp_rdata;
        else                e_rd_c = vecs[i].exp_rdata;
      end
      check({vecs[i].name, " ack latency"}, lat, 32'd2);
      check({vecs[i].name, " enable cycle"}, first_en, 32'd1);
      check({vecs[i].name, " writeEn cycles"}, n_we, {31'd0, vecs[i].we});
      check({vecs[i].name, " readEn cycles"}, n_re, {31'd0, ~vecs[i].we});
      check({vecs[i].name, " foreign ack"}, n_oth, 32'd0);
      check({vecs[i].name, " address/data"}, {31'd0, ok}, 32'd1);
      check({vecs[i].name, " cpu_rdata"}, rd_c, e_rd_c);
      check({vecs[i].name, " dma_rdata"}, rd_d, e_rd_d);
      check({vecs[i].name, " ack one cycle"}, {31'd0, ack_after}, 32'd0);
    end

    // Simultaneous requests right after reset: CPU first, DMA next.
    do_reset();
    cpu_req_a = 1; cpu_addr_a = 32'h40; dma_req_a = 1; dma_addr_a = 32'h80;
    c_at = -1; d_at = -1; stl = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k < 3) stl[k] = cpu_stall_a;
      if (cpu_ack_a && c_at < 0) c_at = k;
      if (dma_ack_a && d_at < 0) d_at = k;
      @(posedge clk); #1;
      if (c_at >= 0) cpu_req_a = 0;
      if (d_at >= 0) dma_req_a = 0;
    end
    check("contend cpu ack cycle", c_at, 32'd2);
    check("contend dma ack cycle", d_at, 32'd5);
    check("contend cpu_stall T..T+2", {29'd0, stl}, 32'b011);

    // Both requests held continuously: acks alternate CPU, DMA every 3 cycles.
    do_reset();
    cpu_req_a = 1; cpu_addr_a = 32'h40; dma_req_a = 1; dma_addr_a = 32'h84;
    c_mask = '0; d_mask = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      c_mask[k] = cpu_ack_a;
      d_mask[k] = dma_ack_a;
    end
    @(posedge clk); #1;
    cpu_req_a = 0; dma_req_a = 0;
    check("held cpu ack pattern", {20'd0, c_mask}, 32'h104);
    check("held dma ack pattern", {20'd0, d_mask}, 32'h820);

    // WAIT_STATES=3 instance: DMA read of a preloaded word.
    do_reset();
    pre_en_b = 1; pre_idx = 6'd17; pre_data = 32'h12345678;
    @(posedge clk); #1;
    pre_en_b = 0;
    dma_req_b = 1; dma_we_b = 0; dma_addr_b = 32'h44;
    n_re = 0; n_we = 0; n_oth = 0; d_at = -1; rd_d = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_re_b) n_re++;
      if (mem_we_b) n_we++;
      if (cpu_ack_b) n_oth++;
      if (dma_ack_b && d_at < 0) begin d_at = k; rd_d = dma_rdata_b; end
      @(posedge clk); #1;
      if (d_at >= 0) dma_req_b = 0;
    end
    check("ws3 readEn cycles", n_re, 32'd4);
    check("ws3 writeEn cycles", n_we, 32'd0);
    check("ws3 dma ack cycle", d_at, 32'd5);
    check("ws3 dma_rdata", rd_d, 32'h12345678);
    check("ws3 cpu ack", n_oth, 32'd0);
    check("ws3 cpu_rdata", cpu_rdata_b, 32'd0);

    // Reset landing in the ACCESS cycle of a write.
    do_reset();
    cpu_req_a = 1; cpu_we_a = 1; cpu_addr_a = 32'h48; cpu_wdata_a = 32'hA5A5A5A5;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1; cpu_req_a = 0; cpu_we_a = 0;
    @(negedge clk);
    check("rst-write writeEn in ACCESS", {31'd0, mem_we_a}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cpu_ack_a | dma_ack_a | mem_we_a) cnt++;
    end
    check("rst-write ack/write after reset", cnt, 32'd0);
    check("rst-write memory word", mem_a[18], 32'd0);
    txn_a(1'b0, 1'b0, 32'h48, 32'h0, lat, first_en, n_we, n_re, n_oth, ok, rd_c, rd_d, ack_after);
    check("rst-write readback latency", lat, 32'd2);
    check("rst-write readback data", rd_c, 32'd0);

    // Random traffic on instance A against the schedule model.
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_a[i];
    m_cyc = 0; m_g = 0; m_free = 0; m_have = 0; m_dma = 0; m_we = 0;
    m_fav_dma = 1'b0; m_addr = '0; m_wdata = '0; m_rd_cpu = '0; m_rd_dma = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      model_step();
      cpu_done = cpu_ack_a;
      dma_done = dma_ack_a;
      @(posedge clk); #1;
      if (cpu_done) cpu_req_a = 0;
      else if (!cpu_req_a && $urandom_range(0, 2) != 0) begin
        cpu_req_a = 1; cpu_we_a = 1'($urandom_range(0, 1));
        cpu_addr_a = 32'($urandom_range(0, 255)); cpu_wdata_a = $urandom;
      end
      if (dma_done) dma_req_a = 0;
      else if (!dma_req_a && $urandom_range(0, 2) != 0) begin
        dma_req_a = 1; dma_we_a = 1'($urandom_range(0, 1));
        dma_addr_a = 32'($urandom_range(0, 255)); dma_wdata_a = $urandom;
      end
    end
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Shares the memory between the CPU MEM stage and a DMA/loader port.
- Each access is serialised through a small FSM with a configurable wait-state count.
- Acknowledges the winning requester and produces a CPU stall signal for the pipeline hazard logic.

Parameters:
- WORD_LEN, 32, data/address width.
- WAIT_STATES, 0, extra ACCESS cycles per transaction (legal range 0..15).
- CPU_FIRST, 1, requester favoured after reset (1 = CPU, 0 = DMA).

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  WORD_LEN  byte address
- cpu_wdata  in  WORD_LEN  write data
- cpu_rdata  out  WORD_LEN  read data; valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/WORD_LEN/WORD_LEN  same semantics as the CPU inputs
- dma_rdata  out  WORD_LEN  read data; valid while dma_ack = 1
- dma_ack  out  1  one-cycle completion pulse
- mem_writeEn  out  1  memory write enable
- mem_readEn  out  1  memory read enable
- mem_address  out  WORD_LEN  memory byte address
- mem_dataIn  out  WORD_LEN  memory write data
- mem_dataOut  in  WORD_LEN  memory combinational read data

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Reset dominates every other event in the same cycle.
  - State goes to IDLE and the wait counter to 0.
  - The round-robin pointer loads CPU_FIRST.
  - All registered outputs are forced to 0: acks, rdata, mem_writeEn, mem_readEn, mem_address, mem_dataIn.
- Reset mid-transaction: the access is abandoned, no write is issued and no ack is produced.
- FSM states:
  - IDLE:
    - If no request, stay in IDLE.
    - Otherwise pick the owner:
      - If only one requester is active, it wins.
      - If both are active, the requester indicated by the round-robin pointer wins.
    - Latch owner, we, addr, wdata; load the counter with WAIT_STATES; go to ACCESS.
    - Toggle the pointer away from the winner.
  - ACCESS:
    - Drive mem_address/mem_dataIn from the latched values.
    - mem_readEn = ~we for every ACCESS cycle.
    - While the counter != 0, decrement it.
    - When the counter == 0 (final cycle):
      - For a write, mem_writeEn = 1 for exactly this one cycle.
      - For a read, capture mem_dataOut into the owner's rdata register.
      - Go to DONE.
  - DONE:
    - Owner's ack = 1 for one cycle and its rdata holds the captured word.
    - mem_* enables are 0. Go to IDLE.
- Latency: request sampled in IDLE at cycle T.
  - ACCESS occupies T+1 .. T+1+WAIT_STATES.
  - Ack arrives at T+2+WAIT_STATES.
  - Minimum 3-cycle turnaround per transaction.
- Handshake rules:
  - Requesters hold req/we/addr/wdata stable until their ack.
  - Changes after latching are ignored for the current transaction.
  - A requester deasserts req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Non-owner rdata and ack stay at their previous rdata value and 0.
- No address translation:
  - The address is passed unmodified. The memory word-aligns it.
  - The memory returns 0 for addresses < 32. The arbiter forwards whatever it returns.
- Back-to-back contention: with both requests held continuously, grants alternate CPU, DMA, CPU, ...
  - Neither requester waits more than one foreign transaction.

Test Plan:
- Reset then CPU write addr 0x40 data 0xDEADBEEF, WAIT_STATES=0 → mem_writeEn high exactly one cycle at T+1; cpu_ack at T+2. A subsequent CPU read of 0x40 returns 0xDEADBEEF with cpu_ack.
- cpu_req and dma_req asserted the same cycle after reset, CPU_FIRST=1 → CPU served first (ack T+2). DMA is served next (ack T+5); cpu_stall high from T until T+2.
- Both requests held for 4 transactions → grant order CPU, DMA, CPU, DMA; exactly one ack per 3 cycles.
- WAIT_STATES=3, DMA read of 0x44 preloaded with 0x12345678 → mem_readEn high 4 cycles; dma_ack at T+5 with dma_rdata 0x12345678.
- CPU read addr 0x10 → cpu_rdata = 0 with cpu_ack.
- rst asserted during the ACCESS cycle of a write to 0x48 → no mem_writeEn pulse and no ack. A later read of 0x48 returns 0.
